// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd PE array sequencing logic.
package wino_pkg;

    localparam int IDX_W_DEF     = 9;
    localparam int OD_W_DEF      = 8;
    localparam int TILE_STEP_3x3 = 4;
    localparam int TILE_STEP_1x1 = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_DRAIN,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/pe_tile_cursor.sv
// Output-tile cursor: walks (x, y) in row-major tile order and reports whether
// the current and the next tile fall inside the configured feature map.
module pe_tile_cursor
    import wino_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_step,
    input  logic             size_type,
    input  logic             advance,
    input  logic [IDX_W-1:0] lim_h,
    input  logic [IDX_W-1:0] lim_w,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic             exists,
    output logic             next_exists
);

    // One extra bit so a step past the last tile never wraps back into range.
    logic [IDX_W:0] x_q, y_q, x_adv, y_adv, y_sum, step_ext;
    logic [2:0]     step_q;

    always_comb begin
        step_ext = (IDX_W+1)'(step_q);
        y_sum    = y_q + step_ext;
        if (y_sum >= {1'b0, lim_w}) begin
            y_adv = '0;
            x_adv = x_q + step_ext;
        end else begin
            y_adv = y_sum;
            x_adv = x_q;
        end
        exists      = (x_q < {1'b0, lim_h}) && (y_q < {1'b0, lim_w});
        next_exists = (x_adv < {1'b0, lim_h}) && (y_adv < {1'b0, lim_w});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            step_q <= '0;
        end else begin
            if (load_step) begin
                step_q <= size_type ? 3'(TILE_STEP_3x3) : 3'(TILE_STEP_1x1);
            end
            if (clear) begin
                x_q <= '0;
                y_q <= '0;
            end else if (advance) begin
                x_q <= x_adv;
                y_q <= y_adv;
            end
        end
    end

    assign x = x_q[IDX_W-1:0];
    assign y = y_q[IDX_W-1:0];

endmodule

// File: rtl/pe_wave_scheduler.sv
// Layer sequencer for the Winograd PE array: issues per-wave data/weight tile
// requests, launches the skew buffers, and waits out the array drain.
module pe_wave_scheduler
    import wino_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int OD_W      = OD_W_DEF,
    parameter int DRAIN_CYC = ROWS + COLS + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [IDX_W-1:0]         cfg_h_i,
    input  logic [IDX_W-1:0]         cfg_w_i,
    input  logic [OD_W-1:0]          cfg_od_i,
    input  logic                     cfg_size_type_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     data_req_valid_o,
    output logic [IDX_W-1:0]         data_req_x_o,
    output logic [IDX_W-1:0]         data_req_y_o,
    output logic [$clog2(COLS)-1:0]  data_req_col_o,
    input  logic                     data_req_ready_i,
    output logic                     weight_req_valid_o,
    output logic [OD_W-1:0]          weight_req_od_o,
    output logic [$clog2(ROWS)-1:0]  weight_req_row_o,
    input  logic                     weight_req_ready_i,
    output logic                     fire_o,
    output logic [COLS-1:0]          fire_col_mask_o,
    output logic [ROWS-1:0]          fire_row_mask_o,
    output logic                     fire_size_type_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    sched_state_e     state;
    logic [IDX_W-1:0] cfg_h, cfg_w;
    logic [OD_W-1:0]  cfg_od;
    logic             size_q;
    logic [OD_W:0]    od_base, od_sum, od_base_nx;
    logic [CW:0]      col_cnt;
    logic [RW:0]      row_cnt;
    logic [DW-1:0]    drain_cnt;
    logic [COLS-1:0]  col_mask;
    logic [ROWS-1:0]  row_mask;
    logic             cur_load, cur_clear, cur_exists, cur_next_exists;
    logic [IDX_W-1:0] cur_x, cur_y;
    logic             data_fin, data_fin_nx, wt_fin, wt_fin_nx;
    logic             data_hs, wt_hs, drain_end, cfg_zero;

    pe_tile_cursor #(.IDX_W(IDX_W)) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .clear       (cur_clear),
        .load_step   (cur_load),
        .size_type   (cfg_size_type_i),
        .advance     (data_hs),
        .lim_h       (cfg_h),
        .lim_w       (cfg_w),
        .x           (cur_x),
        .y           (cur_y),
        .exists      (cur_exists),
        .next_exists (cur_next_exists)
    );

    // The *_fin_nx terms fold in this cycle's handshake so FIRE follows the
    // last accepted request with no idle cycle in between.
    always_comb begin
        od_sum             = od_base + (OD_W+1)'(row_cnt);
        data_fin           = (col_cnt == (CW+1)'(COLS)) || !cur_exists;
        wt_fin             = (row_cnt == (RW+1)'(ROWS)) || (od_sum >= {1'b0, cfg_od});
        data_req_valid_o   = (state == S_LOAD) && !data_fin;
        weight_req_valid_o = (state == S_LOAD) && !wt_fin;
        data_hs            = data_req_valid_o && data_req_ready_i;
        wt_hs              = weight_req_valid_o && weight_req_ready_i;
        data_fin_nx        = data_hs ? ((col_cnt + (CW+1)'(1) == (CW+1)'(COLS)) || !cur_next_exists)
                                     : data_fin;
        wt_fin_nx          = wt_hs ? ((row_cnt + (RW+1)'(1) == (RW+1)'(ROWS)) ||
                                      (od_sum + (OD_W+1)'(1) >= {1'b0, cfg_od}))
                                   : wt_fin;
        drain_end          = (state == S_DRAIN) && (drain_cnt == DW'(1));
        od_base_nx         = cur_exists ? od_base : od_base + (OD_W+1)'(ROWS);
        cfg_zero           = (cfg_h_i == '0) || (cfg_w_i == '0) || (cfg_od_i == '0);
        cur_load           = (state == S_IDLE) && start_i;
        cur_clear          = cur_load || (drain_end && !cur_exists);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cfg_h     <= '0;
            cfg_w     <= '0;
            cfg_od    <= '0;
            size_q    <= 1'b0;
            od_base   <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            col_mask  <= '0;
            row_mask  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            fire_o    <= 1'b0;
        end else begin
            fire_o <= 1'b0;
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cfg_h    <= cfg_h_i;
                        cfg_w    <= cfg_w_i;
                        cfg_od   <= cfg_od_i;
                        size_q   <= cfg_size_type_i;
                        od_base  <= '0;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        col_mask <= '0;
                        row_mask <= '0;
                        if (cfg_zero) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= S_LOAD;
                            busy_o <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (data_hs) begin
                        col_mask[col_cnt[CW-1:0]] <= 1'b1;
                        col_cnt <= col_cnt + (CW+1)'(1);
                    end
                    if (wt_hs) begin
                        row_mask[row_cnt[RW-1:0]] <= 1'b1;
                        row_cnt <= row_cnt + (RW+1)'(1);
                    end
                    if (data_fin_nx && wt_fin_nx) begin
                        state  <= S_FIRE;
                        fire_o <= 1'b1;
                    end
                end
                S_FIRE: begin
                    drain_cnt <= DW'(DRAIN_CYC);
                    state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - DW'(1);
                    if (drain_end) begin
                        od_base <= od_base_nx;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        if (od_base_nx >= {1'b0, cfg_od}) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state    <= S_LOAD;
                            col_mask <= '0;
                            row_mask <= '0;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_req_x_o     = cur_x;
    assign data_req_y_o     = cur_y;
    assign data_req_col_o   = col_cnt[CW-1:0];
    assign weight_req_od_o  = od_sum[OD_W-1:0];
    assign weight_req_row_o = row_cnt[RW-1:0];
    assign fire_col_mask_o  = col_mask;
    assign fire_row_mask_o  = row_mask;
    assign fire_size_type_o = size_q;

endmodule

// File: doc/pe_wave_scheduler.md
Name: pe_wave_scheduler

Overview:
Sequences the Winograd PE array. Latches a layer configuration (H, W, OD, kernel size type), then walks the output-tile space in waves. Each wave requests one data tile per array column (top edge) and one weight tile per array row (left edge), pulses fire_o to launch the skew buffers into the array, and waits out the array drain before starting the next wave. It sits between the layer-config register and the data/weight fetch units that feed the Itrans/Wtrans edges.

Parameters:
ROWS, 4, PE array rows; each row receives one weight tile (one OD) per wave.
COLS, 4, PE array columns; each column receives one data tile per wave.
IDX_W, 9, tile x/y index width (max 511).
OD_W, 8, output-depth index width.
DRAIN_CYC, ROWS+COLS+2, cycles from fire until the last PE result_valid has retired.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
start_i  in  1  begin layer; sampled only in IDLE
cfg_h_i  in  IDX_W  input height
cfg_w_i  in  IDX_W  input width
cfg_od_i  in  OD_W  number of output channels
cfg_size_type_i  in  1  1 = 3x3 kernel (tile step 4), 0 = 1x1 (tile step 6)
busy_o  out  1  high from the cycle after start until done
done_o  out  1  one-cycle pulse at layer end
data_req_valid_o  out  1  data tile request valid
data_req_x_o  out  IDX_W  tile first-element row index
data_req_y_o  out  IDX_W  tile first-element column index
data_req_col_o  out  clog2(COLS)  destination array column
data_req_ready_i  in  1  fetch unit accepts the data request
weight_req_valid_o  out  1  weight tile request valid
weight_req_od_o  out  OD_W  output channel of the weight tile
weight_req_row_o  out  clog2(ROWS)  destination array row
weight_req_ready_i  in  1  fetch unit accepts the weight request
fire_o  out  1  one-cycle launch of the skew buffers into the array
fire_col_mask_o  out  COLS  columns holding a valid data tile this wave
fire_row_mask_o  out  ROWS  rows holding a valid weight tile this wave
fire_size_type_o  out  1  latched size type, drives the PE weight_size_type

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs, cursors and counters 0.
- A reset asserted mid-layer aborts the layer immediately. No done_o is produced.
- States: IDLE, LOAD, FIRE, DRAIN, DONE.
- IDLE:
  - On start_i, latch the configuration, set STEP = 4 if size_type else 6, and clear the cursors (x=0, y=0, od_base=0). Next state is LOAD.
  - If cfg_h==0, cfg_w==0 or cfg_od==0, go to DONE instead; no requests are issued.
- Tile cursor (x, y):
  - A tile exists iff x<cfg_h and y<cfg_w. Partial edge tiles are issued; the downstream logic clips them.
  - Advance: y+=STEP. If the new y>=cfg_w, set y=0 and x+=STEP.
- LOAD: the data and weight streams run independently and may both handshake in the same cycle.
  - Data stream: column counter c=0..COLS-1. While the cursor tile exists, present (x, y, c) with valid=1.
    - On valid&&ready, set mask bit c, advance the cursor, c++.
    - If the tile does not exist, the remaining columns are unmasked and the data stream is finished.
  - Weight stream: row counter r=0..ROWS-1. Present od=od_base+r with valid=1 while od_base+r<cfg_od.
    - On handshake, set mask bit r, r++.
  - Payload is held stable while valid && !ready; valid never drops without a handshake.
  - Leave LOAD for FIRE when both streams are finished.
- FIRE: exactly one cycle.
  - fire_o=1; masks are valid this cycle.
  - Load the drain counter with DRAIN_CYC.
- DRAIN: lasts DRAIN_CYC cycles. No requests are issued. Then evaluate the wave end:
  - If the cursor tile does not exist: set cursor to (0,0) and od_base+=ROWS.
  - If od_base>=cfg_od, go to DONE; otherwise go to LOAD and clear both masks.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- start_i is ignored when the state is not IDLE.
- Width rules:
  - Cursor arithmetic uses IDX_W+1 bits so that x+STEP cannot wrap past 511.
  - od_base uses OD_W+1 bits.
- Loop order (outer to inner): od_base, x, y.

Decomposition:
- Package wino_pkg:
  - TILE_STEP_3x3=4, TILE_STEP_1x1=6
  - sched_state_e enum
  - IDX_W and OD_W defaults
- Sub-module pe_tile_cursor: owns x/y/step and the advance/exists logic, reused later by the result writeback.

Test Plan:
1. Defaults; H=W=8, size=1, OD=8; readies tied to 1; start at cycle 0.
   - Data (0,0),(0,4),(4,0),(4,4) to cols 0-3 in cycles 1-4; weight od 0-3 in cycles 1-4.
   - fire_o at 5 with both masks 4'b1111; DRAIN cycles 6-15.
   - Second wave requests od 4-7 in 16-19, fire at 20; done_o at cycle 31.
2. H=8, W=4, size=1, OD=2.
   - One wave: data (0,0) col0 and (4,0) col1; weight od 0,1.
   - fire_col_mask=4'b0011, fire_row_mask=4'b0011; then done.
3. H=W=12, size=0, OD=4: step 6.
   - Data tiles (0,0),(0,6),(6,0),(6,6); one wave; done.
4. Backpressure: data_req_ready_i low for 3 cycles on the second request.
   - Valid and payload stay constant; the weight stream completes independently; fire is delayed by 3 cycles.
5. cfg_od=0 with start: no request valid, done_o pulses one cycle later. Separately, a start pulse during DRAIN has no effect.
6. reset=0 during LOAD of wave 2: the next cycle has all outputs 0 and state IDLE, and no done_o. A new start then runs test 1 cleanly.
